pdm_serializer: RTL and testbench
=================================

Name: pdm_serializer

Overview:
- PCM-to-PDM transmitter. It accepts signed 16-bit PCM samples over a valid/ready handshake and generates the PDM bit clock itself.
- Each sample is converted into OVERSAMPLE 1-bit PDM symbols by a first-order sigma-delta (phase-accumulator) modulator.
- It drives a PDM DAC/amplifier and complements the PDM capture path. Typical feed is from the sample FIFO.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- PDM_CLK_FREQ, 3_072_000, target PDM clock in Hz. Half period HALF = CLK_FREQ/(2*PDM_CLK_FREQ), integer division (16 at defaults, giving 3.125 MHz actual). HALF >= 2 is required.
- OVERSAMPLE, 64, PDM bits per PCM sample.
- DATA_WIDTH, 16, PCM sample width (signed, two's complement).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request; low forces idle.
- pcm_in  in  DATA_WIDTH  signed PCM sample.
- pcm_valid  in  1  pcm_in valid.
- pcm_ready  out  1  holding register empty; a transfer occurs when valid && ready on a clk edge.
- pdm_clk  out  1  generated PDM clock, 50% duty.
- pdm_data  out  1  PDM bitstream; changes only on pdm_clk falling edges.
- underrun  out  1  one-cycle pulse when a sample boundary finds no sample available.

Behaviour:
- Reset (async assert, sync release): pdm_clk=0, pdm_data=0, underrun=0, hold empty (pcm_ready=1), acc=0, div_cnt=0, bit_cnt=0, state=IDLE.
- Storage:
  - Holding register `hold` plus flag hold_full, and current sample register `cur`.
  - pcm_ready = !hold_full, combinational from the flag.
  - Handshake writes `hold` and sets hold_full.
- State IDLE:
  - pdm_clk=0, pdm_data=0, divider, bit_cnt and acc held at 0.
  - If enable && hold_full: cur<=hold, hold_full<=0, go RUN.
  - A handshake in the same cycle is not bypassed; it fills hold on the next accept.
- State RUN, clock divider:
  - div_cnt counts 0..HALF-1.
  - At HALF-1, pdm_clk toggles and div_cnt<=0.
  - The first rising edge occurs HALF cycles after entering RUN.
- State RUN, falling edge (toggle 1->0), in the same clk edge:
  - u = cur + 2^(DATA_WIDTH-1), unsigned offset-binary.
  - sum = acc + u, DATA_WIDTH+1 bits.
  - pdm_data <= sum[DATA_WIDTH]; acc <= sum[DATA_WIDTH-1:0].
  - bit_cnt++.
  - The density of ones over OVERSAMPLE bits is u/2^DATA_WIDTH.
- Sample boundary (falling edge where bit_cnt reaches OVERSAMPLE, then bit_cnt<=0):
  - hold_full: cur<=hold, hold_full<=0.
  - hold empty and handshake this same cycle: cur<=pcm_in (bypass), hold stays empty, no underrun.
  - hold empty, no handshake: cur<=0 (midscale silence), underrun=1 for one cycle.
  - acc is never cleared at boundaries.
- Simultaneous handshake and boundary with hold_full: cur takes the old hold, hold takes pcm_in, and hold_full stays 1. This cannot occur while ready=0, so it is only legal through the bypass case above.
- enable falls in RUN:
  - Finish the current pdm_clk period; on the next falling edge, drive pdm_data=0 and return to IDLE.
  - acc and bit_cnt are cleared; hold and hold_full are retained.
- Reset mid-operation immediately forces all reset values; any sample in hold is discarded.

Test Plan:
- Timing: enable=1, one sample 0 -> pdm_clk period 32 clk, high 16 / low 16. The first rising edge comes 16 cycles after RUN entry. pdm_data is stable across every rising edge.
- Midscale: stream of pcm_in=16'h0000 -> pdm_data 0,1,0,1,...; exactly 32 ones per 64 bits; no underrun.
- Extremes: pcm_in=16'h8000 -> 0 ones per 64 bits. pcm_in=16'h7FFF -> 63 ones; first bit 0, the rest 1 within the first sample.
- Underrun: one sample then none -> underrun pulses exactly once at the 64th falling edge; the following bits alternate as for midscale.
- Backpressure: pcm_valid held high with a counting pattern -> one accept per 64 PDM bits. pcm_ready drops after each accept and rises on the boundary. No sample is lost or duplicated (checked against a reference model).
- Reset/enable: assert rst_n low mid-sample -> all outputs are 0 and pcm_ready=1 within the same cycle. Drop enable -> pdm_clk stops low after the current period completes, with no runt pulse.

Source files
------------

// File: rtl/pdm_serializer_if.sv
// PCM sample handshake bundle between the sample source (e.g. a FIFO) and
// the PDM serializer. The master drives samples, the slave returns ready.
`timescale 1ns/1ps
interface pdm_serializer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] pcm_in;
  logic                  pcm_valid;
  logic                  pcm_ready;

  modport master (output pcm_in, output pcm_valid, input pcm_ready);
  modport slave  (input pcm_in, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_serializer.sv
// PCM-to-PDM transmitter: takes signed PCM samples over valid/ready, makes
// its own PDM bit clock and converts every sample into OVERSAMPLE bits with
// a first-order sigma-delta (phase accumulator) modulator.
// HALF = CLK_FREQ/(2*PDM_CLK_FREQ) must be at least 2.
`timescale 1ns/1ps
module pdm_serializer #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int PDM_CLK_FREQ = 3_072_000,
  parameter int OVERSAMPLE   = 64,
  parameter int DATA_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  pdm_serializer_if.slave  pcm,
  output logic             pdm_clk,
  output logic             pdm_data,
  output logic             underrun
);

  localparam int HALF  = CLK_FREQ / (2 * PDM_CLK_FREQ);
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CNT_W = $clog2(OVERSAMPLE + 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(HALF - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OVERSAMPLE);

  // STOP keeps the divider running until the current PDM period ends.
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic                  pdm_clk_q, pdm_clk_d;
  logic                  pdm_data_q, pdm_data_d;
  logic                  underrun_q, underrun_d;

  logic                  accept;
  logic                  tick;
  logic                  fall;
  logic [DATA_WIDTH-1:0] u_val;
  logic [DATA_WIDTH:0]   sum;
  logic [CNT_W-1:0]      bit_cnt_inc;

  assign pcm.pcm_ready = !hold_full_q;
  assign accept        = pcm.pcm_valid && !hold_full_q;
  assign tick          = (div_cnt_q == DIV_MAX);
  assign fall          = tick && pdm_clk_q;
  // Offset-binary conversion of the signed sample is an MSB inversion.
  assign u_val         = {~cur_q[DATA_WIDTH-1], cur_q[DATA_WIDTH-2:0]};
  assign sum           = {1'b0, acc_q} + {1'b0, u_val};
  assign bit_cnt_inc   = bit_cnt_q + CNT_W'(1);

  assign pdm_clk  = pdm_clk_q;
  assign pdm_data = pdm_data_q;
  assign underrun = underrun_q;

  // State, clock divider, modulator and sample-buffer next-state logic.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    acc_d       = acc_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cur_d       = cur_q;
    pdm_clk_d   = pdm_clk_q;
    pdm_data_d  = pdm_data_q;
    underrun_d  = 1'b0;

    if (accept) begin
      hold_d      = pcm.pcm_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        pdm_clk_d  = 1'b0;
        pdm_data_d = 1'b0;
        div_cnt_d  = '0;
        bit_cnt_d  = '0;
        acc_d      = '0;
        if (enable && hold_full_q) begin
          cur_d       = hold_q;
          hold_full_d = 1'b0;
          state_d     = RUN;
        end
      end

      RUN, STOP: begin
        if (tick) begin
          div_cnt_d = '0;
          pdm_clk_d = ~pdm_clk_q;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (state_q == RUN && !enable) begin
          state_d = STOP;
        end

        if (fall) begin
          if (state_q == STOP || !enable) begin
            pdm_data_d = 1'b0;
            acc_d      = '0;
            bit_cnt_d  = '0;
            div_cnt_d  = '0;
            pdm_clk_d  = 1'b0;
            state_d    = IDLE;
          end else begin
            pdm_data_d = sum[DATA_WIDTH];
            acc_d      = sum[DATA_WIDTH-1:0];
            if (bit_cnt_inc == LAST_BIT) begin
              bit_cnt_d = '0;
              if (hold_full_q) begin
                cur_d       = hold_q;
                hold_full_d = 1'b0;
              end else if (accept) begin
                cur_d       = pcm.pcm_in;
                hold_d      = hold_q;
                hold_full_d = 1'b0;
              end else begin
                cur_d      = '0;
                underrun_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_inc;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register bank; reset discards any buffered sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      acc_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cur_q       <= '0;
      pdm_clk_q   <= 1'b0;
      pdm_data_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      acc_q       <= acc_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cur_q       <= cur_d;
      pdm_clk_q   <= pdm_clk_d;
      pdm_data_q  <= pdm_data_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pdm_serializer.sv
// Directed bench for pdm_serializer: expected PDM bits are queued when a
// sample is accepted and popped at every observed pdm_clk falling edge.
`timescale 1ns/1ps
module tb_pdm_serializer;

  localparam int HALF = 16;
  localparam int OS   = 64;
  localparam int DW   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic pdm_clk, pdm_data, underrun;

  pdm_serializer_if #(.DATA_WIDTH(DW)) bus ();

  pdm_serializer #(
    .CLK_FREQ(100_000_000), .PDM_CLK_FREQ(3_072_000),
    .OVERSAMPLE(OS), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pcm(bus),
    .pdm_clk(pdm_clk), .pdm_data(pdm_data), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        exp_q[$];
  logic [15:0] m_acc;
  bit          sb_on, bp_mode;
  int          fall_cnt, rise_cnt, hi_len, ones, ur_cycles, ur_first;
  int          win_ones[8];
  logic        clk_prev, data_prev, ready_prev;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference sigma-delta: queue the OS bits one sample should produce.
  task automatic modelPush(input logic [15:0] s);
    logic [15:0] u;
    logic [16:0] sum;
    for (int i = 0; i < OS; i++) begin
      u = s ^ 16'h8000;
      sum = {1'b0, m_acc} + {1'b0, u};
      exp_q.push_back(sum[16]);
      m_acc = sum[15:0];
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    enable = 1'b0;
    bus.pcm_valid = 1'b0;
    bus.pcm_in = '0;
    exp_q.delete();
    m_acc = '0;
    sb_on = 1'b1;
    bp_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; leaves pcm_valid high, returns one negedge after the accept edge.
  task automatic applyStimulus(input logic [15:0] s);
    bit got = 1'b0;
    bus.pcm_in = s;
    bus.pcm_valid = 1'b1;
    for (int t = 0; t < 5000; t++) begin
      if (bus.pcm_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("accept_timeout", 32'(got), 1);
    if (got) begin
      modelPush(s);
      @(negedge clk);
      checkOutput("ready_drop_after_accept", 32'(bus.pcm_ready), 0);
    end
  endtask

  task automatic waitFalls(input int n);
    for (int t = 0; t < n * 2 * HALF + 400; t++) begin
      if (fall_cnt >= n) break;
      @(negedge clk);
    end
    checkOutput("wait_falls_timeout", 32'(fall_cnt >= n), 1);
  endtask

  // Output monitor: edge detection, period/stability checks, scoreboard pops.
  always @(negedge clk) begin
    logic e;
    if (!rst_n) begin
      fall_cnt = 0; rise_cnt = 0; hi_len = 0; ones = 0;
      ur_cycles = 0; ur_first = -1;
      foreach (win_ones[i]) win_ones[i] = -1;
      clk_prev = 1'b0; data_prev = 1'b0; ready_prev = 1'b1;
    end else begin
      if (pdm_clk && !clk_prev) begin
        rise_cnt++;
        checkOutput("data_stable_at_rise", 32'(pdm_data), 32'(data_prev));
      end
      if (pdm_clk) hi_len++;
      if (!pdm_clk && clk_prev) begin
        fall_cnt++;
        checkOutput("high_len", hi_len, HALF);
        hi_len = 0;
        ones += int'(pdm_data);
        if (fall_cnt % OS == 0) begin
          if (fall_cnt / OS <= 8) win_ones[fall_cnt / OS - 1] = ones;
          ones = 0;
        end
        if (sb_on && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput($sformatf("bit%0d", fall_cnt), 32'(pdm_data), 32'(e));
        end
      end
      if (underrun) begin
        if (ur_cycles == 0) ur_first = fall_cnt;
        ur_cycles++;
      end
      if (bp_mode && bus.pcm_ready && !ready_prev)
        checkOutput("ready_rise_at_boundary", fall_cnt % OS, 0);
      clk_prev = pdm_clk;
      data_prev = pdm_data;
      ready_prev = bus.pcm_ready;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int r0;
    bit found;

    // Reset state
    applyReset();
    checkOutput("reset_pdm_clk", 32'(pdm_clk), 0);
    checkOutput("reset_pdm_data", 32'(pdm_data), 0);
    checkOutput("reset_underrun", 32'(underrun), 0);
    checkOutput("reset_ready", 32'(bus.pcm_ready), 1);

    // Timing plus underrun: one sample 0, then silence.
    enable = 1'b1;
    applyStimulus(16'h0000);
    bus.pcm_valid = 1'b0;
    modelPush(16'h0000);
    modelPush(16'h0000);
    n = 0;
    while (!pdm_clk && n < 100) begin @(negedge clk); n++; end
    checkOutput("first_rise_after_accept", n, HALF + 1);
    n = 0;
    while (pdm_clk && n < 100) begin @(negedge clk); n++; end
    checkOutput("first_high_len", n, HALF);
    n = 0;
    while (!pdm_clk && n < 100) begin @(negedge clk); n++; end
    checkOutput("first_low_len", n, HALF);
    waitFalls(100);
    checkOutput("underrun_pulse_count", ur_cycles, 1);
    checkOutput("underrun_at_fall", ur_first, OS);

    // Midscale stream
    applyReset();
    enable = 1'b1;
    repeat (3) applyStimulus(16'h0000);
    bus.pcm_valid = 1'b0;
    modelPush(16'h0000);
    waitFalls(150);
    checkOutput("midscale_no_underrun", ur_cycles, 0);
    checkOutput("midscale_ones_w0", win_ones[0], 32);
    checkOutput("midscale_ones_w1", win_ones[1], 32);

    // Negative full scale
    applyReset();
    enable = 1'b1;
    applyStimulus(16'h8000);
    bus.pcm_valid = 1'b0;
    waitFalls(OS);
    checkOutput("min_ones", win_ones[0], 0);

    // Positive full scale
    applyReset();
    enable = 1'b1;
    applyStimulus(16'h7FFF);
    bus.pcm_valid = 1'b0;
    waitFalls(OS);
    checkOutput("max_ones", win_ones[0], 63);

    // Backpressure with counting pattern, valid held high
    applyReset();
    enable = 1'b1;
    bp_mode = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(16'(16'h1357 * i + 16'hA000));
    bus.pcm_valid = 1'b0;
    modelPush(16'h0000);
    waitFalls(7 * OS);
    bp_mode = 1'b0;
    checkOutput("bp_scoreboard_drained", exp_q.size(), 0);
    checkOutput("bp_first_underrun", ur_first, 6 * OS);

    // Reset mid-sample
    applyReset();
    enable = 1'b1;
    applyStimulus(16'h0000);
    applyStimulus(16'h0000);
    bus.pcm_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (pdm_clk && pdm_data && !bus.pcm_ready) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("midreset_setup", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_pdm_clk", 32'(pdm_clk), 0);
    checkOutput("midreset_pdm_data", 32'(pdm_data), 0);
    checkOutput("midreset_underrun", 32'(underrun), 0);
    checkOutput("midreset_ready", 32'(bus.pcm_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("midreset_hold_discarded", 32'(pdm_clk), 0);

    // Enable drop during a low phase
    applyReset();
    enable = 1'b1;
    applyStimulus(16'h0000);
    applyStimulus(16'h0000);
    bus.pcm_valid = 1'b0;
    waitFalls(40);
    sb_on = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (!pdm_clk) break;
      @(negedge clk);
    end
    enable = 1'b0;
    r0 = rise_cnt;
    repeat (120) @(negedge clk);
    checkOutput("stop_rises_after_drop", rise_cnt - r0, 1);
    checkOutput("stop_pdm_clk_low", 32'(pdm_clk), 0);
    checkOutput("stop_pdm_data_low", 32'(pdm_data), 0);
    checkOutput("stop_hold_retained", 32'(bus.pcm_ready), 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("restart_consumes_hold", 32'(bus.pcm_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
